// File: rtl/ugt_share_arbiter.sv
// Round-robin arbiter sharing one unsigned greater-than comparator among N requesters.
// Optional statistics ports are enabled by defining UGT_SHARE_ARBITER_STATS_EN.

module ugt_cmp #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             out
);
  assign out = (in0 > in1);
endmodule

module ugt_share_arbiter #(
  parameter int WIDTH = 4,
  parameter int N     = 4,
  parameter int IDW   = 2
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [N-1:0]       req_valid,
  input  logic [N*WIDTH-1:0] req_a,
  input  logic [N*WIDTH-1:0] req_b,
  output logic [N-1:0]       req_ready,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [IDW-1:0]     resp_id,
  output logic               resp_gt
`ifdef UGT_SHARE_ARBITER_STATS_EN
  ,
  output logic [15:0]        txn_count,
  output logic [N-1:0]       last_grant_onehot
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [IDW-1:0]    r_rr_ptr;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [IDW-1:0]    r_id;
  logic [IDW-1:0]    r_resp_id;
  logic              r_resp_gt;

  logic [WIDTH-1:0]  w_req_a [N];
  logic [WIDTH-1:0]  w_req_b [N];
  logic [IDW-1:0]    w_rot_idx [N];
  logic [N-1:0]      w_rot_valid;

  logic              w_grant_found;
  logic [IDW-1:0]    w_grant_idx;
  logic [N-1:0]      w_grant_onehot;
  logic [N-1:0]      w_req_ready;
  logic              w_resp_valid;
  logic              w_accept;
  logic              w_handshake;
  logic              w_cmp_gt;

  // Unpack operand buses and build the rotated search order starting at r_rr_ptr.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      logic [IDW:0] w_sum;
      assign w_req_a[gi] = req_a[gi*WIDTH +: WIDTH];
      assign w_req_b[gi] = req_b[gi*WIDTH +: WIDTH];
      assign w_sum       = {1'b0, r_rr_ptr} + (IDW+1)'(gi);
      assign w_rot_idx[gi] = (w_sum >= (IDW+1)'(N)) ?
                             IDW'(w_sum - (IDW+1)'(N)) : w_sum[IDW-1:0];
      assign w_rot_valid[gi] = req_valid[w_rot_idx[gi]];
    end
  endgenerate

  // Lowest rotation offset with a pending request wins.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot_valid[i]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = w_rot_idx[i];
      end
    end
  end

  always_comb begin
    w_grant_onehot = '0;
    if (w_grant_found) begin
      w_grant_onehot[w_grant_idx] = 1'b1;
    end
  end

  ugt_cmp #(
    .WIDTH (WIDTH)
  ) u_cmp (
    .in0 (r_a),
    .in1 (r_b),
    .out (w_cmp_gt)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_grant_found) w_state_next = S_CMP;
      S_CMP:   w_state_next = S_RESP;
      S_RESP:  if (resp_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    w_req_ready  = '0;
    w_resp_valid = 1'b0;
    case (r_state)
      S_IDLE:  if (!RESET) w_req_ready = w_grant_onehot;
      S_RESP:  w_resp_valid = 1'b1;
      default: ;
    endcase
  end

  assign w_accept    = (r_state == S_IDLE) && w_grant_found;
  assign w_handshake = w_resp_valid && resp_ready;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_rr_ptr  <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_id      <= '0;
      r_resp_id <= '0;
      r_resp_gt <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a  <= w_req_a[w_grant_idx];
        r_b  <= w_req_b[w_grant_idx];
        r_id <= w_grant_idx;
      end
      if (r_state == S_CMP) begin
        r_resp_gt <= w_cmp_gt;
        r_resp_id <= r_id;
      end
      // Priority moves just past the requester that was served.
      if (w_handshake) begin
        r_rr_ptr <= (r_id == IDW'(N - 1)) ? '0 : r_id + IDW'(1);
      end
    end
  end

  assign req_ready  = w_req_ready;
  assign resp_valid = w_resp_valid;
  assign resp_id    = r_resp_id;
  assign resp_gt    = r_resp_gt;

`ifdef UGT_SHARE_ARBITER_STATS_EN
  logic [15:0]  r_txn_count;
  logic [N-1:0] r_last_grant_onehot;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_txn_count         <= '0;
      r_last_grant_onehot <= '0;
    end else begin
      if (w_handshake && (r_txn_count != 16'hFFFF)) begin
        r_txn_count <= r_txn_count + 16'd1;
      end
      if (w_accept) begin
        r_last_grant_onehot <= w_grant_onehot;
      end
    end
  end

  assign txn_count         = r_txn_count;
  assign last_grant_onehot = r_last_grant_onehot;
`endif

endmodule

// File: tb/tb_ugt_share_arbiter.sv
// Directed self-checking bench for ugt_share_arbiter (WIDTH=4, N=4).
// Stats scenario runs only when UGT_SHARE_ARBITER_STATS_EN is defined.

module tb_ugt_share_arbiter;
  localparam int WIDTH = 4;
  localparam int N     = 4;
  localparam int IDW   = 2;

  logic               CLK;
  logic               RESET;
  logic [N-1:0]       req_valid;
  logic [N*WIDTH-1:0] req_a;
  logic [N*WIDTH-1:0] req_b;
  logic [N-1:0]       req_ready;
  logic               resp_valid;
  logic               resp_ready;
  logic [IDW-1:0]     resp_id;
  logic               resp_gt;
`ifdef UGT_SHARE_ARBITER_STATS_EN
  logic [15:0]        txn_count;
  logic [N-1:0]       last_grant_onehot;
`endif

  int n_tests;
  int n_fail;

  ugt_share_arbiter #(
    .WIDTH (WIDTH),
    .N     (N),
    .IDW   (IDW)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_gt    (resp_gt)
`ifdef UGT_SHARE_ARBITER_STATS_EN
    ,
    .txn_count         (txn_count),
    .last_grant_onehot (last_grant_onehot)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int k, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_valid[k] = 1'b1;
    req_a[k*WIDTH +: WIDTH] = a;
    req_b[k*WIDTH +: WIDTH] = b;
  endtask

  task automatic test_reset;
    @(posedge CLK);
    #1;
    n_tests++;
    if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    n_tests++;
    if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    n_tests++;
    if (resp_id !== 2'd0) begin n_fail++; $display("FAIL reset_resp_id: got %0d expected 0", resp_id); end
    n_tests++;
    if (resp_gt !== 1'b0) begin n_fail++; $display("FAIL reset_resp_gt: got %b expected 0", resp_gt); end
    req_valid = 4'hF;
    #1;
    n_tests++;
    if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_gates_ready: got %b expected 0000", req_ready); end
    tick;
    n_tests++;
    if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_hold_valid: got %b expected 0", resp_valid); end
    req_valid = '0;
    RESET = 1'b0;
    #1;
    n_tests++;
    if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL idle_ready: got %b expected 0000", req_ready); end
    tick;
    n_tests++;
    if (resp_valid !== 1'b0 || resp_id !== 2'd0) begin
      n_fail++; $display("FAIL idle_after_reset: got valid=%b id=%0d expected valid=0 id=0", resp_valid, resp_id);
    end
  endtask

  task automatic test_single;
    logic [WIDTH-1:0] a_tab [2];
    logic [WIDTH-1:0] b_tab [2];
    logic             gt_tab [2];
    a_tab[0] = 4'h9; b_tab[0] = 4'h3; gt_tab[0] = 1'b1;
    a_tab[1] = 4'h7; b_tab[1] = 4'h7; gt_tab[1] = 1'b0;
    for (int t = 0; t < 2; t++) begin
      set_req(2, a_tab[t], b_tab[t]);
      #1;
      n_tests++;
      if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready[%0d]: got %b expected 0100", t, req_ready); end
      tick;
      req_valid = '0;
      #1;
      n_tests++;
      if (req_ready !== 4'b0000 || resp_valid !== 1'b0) begin
        n_fail++; $display("FAIL single_cmp[%0d]: got ready=%b valid=%b expected 0000/0", t, req_ready, resp_valid);
      end
      tick;
      n_tests++;
      if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_gt !== gt_tab[t]) begin
        n_fail++; $display("FAIL single_resp[%0d]: got v=%b id=%0d gt=%b expected v=1 id=2 gt=%b",
                           t, resp_valid, resp_id, resp_gt, gt_tab[t]);
      end
      $display("[TB] single txn a=%h b=%h id=%0d gt=%b", a_tab[t], b_tab[t], resp_id, resp_gt);
      resp_ready = 1'b1;
      tick;
      resp_ready = 1'b0;
      n_tests++;
      if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL single_release[%0d]: got %b expected 0", t, resp_valid); end
    end
  endtask

  task automatic test_round_robin;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_gt;
    int           k;
    exp_gt = 4'b1001;
    RESET = 1'b1;
    tick;
    RESET = 1'b0;
    set_req(0, 4'h1, 4'h0);
    set_req(1, 4'h0, 4'h1);
    set_req(2, 4'hF, 4'hF);
    set_req(3, 4'hF, 4'h0);
    resp_ready = 1'b1;
    #1;
    for (int t = 0; t < 5; t++) begin
      k = t % N;
      exp_rdy = 4'b0001 << k;
      n_tests++;
      if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b expected %b", t, req_ready, exp_rdy); end
      tick;
      n_tests++;
      if (req_ready !== 4'b0000 || resp_valid !== 1'b0) begin
        n_fail++; $display("FAIL rr_cmp[%0d]: got ready=%b valid=%b expected 0000/0", t, req_ready, resp_valid);
      end
      tick;
      n_tests++;
      if (resp_valid !== 1'b1 || resp_id !== IDW'(k) || resp_gt !== exp_gt[k]) begin
        n_fail++; $display("FAIL rr_resp[%0d]: got v=%b id=%0d gt=%b expected v=1 id=%0d gt=%b",
                           t, resp_valid, resp_id, resp_gt, k, exp_gt[k]);
      end
      $display("[TB] rr txn %0d id=%0d gt=%b", t, resp_id, resp_gt);
      tick;
    end
    req_valid  = '0;
    resp_ready = 1'b0;
    #1;
  endtask

  task automatic test_backpressure;
    set_req(1, 4'hC, 4'h5);
    #1;
    n_tests++;
    if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_grant1: got %b expected 0010", req_ready); end
    tick;
    req_valid = '0;
    set_req(3, 4'h2, 4'h3);
    tick;
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_gt !== 1'b1 || req_ready !== 4'b0000) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got v=%b id=%0d gt=%b rdy=%b expected v=1 id=1 gt=1 rdy=0000",
                           i, resp_valid, resp_id, resp_gt, req_ready);
      end
      if (i < 4) tick;
    end
    resp_ready = 1'b1;
    #1;
    n_tests++;
    if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_handshake_ready: got %b expected 0000", req_ready); end
    $display("[TB] bp txn id=%0d gt=%b", resp_id, resp_gt);
    tick;
    resp_ready = 1'b0;
    #1;
    n_tests++;
    if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_grant3: got %b expected 1000", req_ready); end
    tick;
    req_valid = '0;
    tick;
    n_tests++;
    if (resp_valid !== 1'b1 || resp_id !== 2'd3 || resp_gt !== 1'b0) begin
      n_fail++; $display("FAIL bp_resp3: got v=%b id=%0d gt=%b expected v=1 id=3 gt=0", resp_valid, resp_id, resp_gt);
    end
    $display("[TB] bp txn id=%0d gt=%b", resp_id, resp_gt);
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    // Serve requester 1 first so the pointer sits at 2, away from its reset value.
    set_req(1, 4'h3, 4'h3);
    #1;
    n_tests++;
    if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL rst_pre_grant: got %b expected 0010", req_ready); end
    tick;
    req_valid = '0;
    tick;
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    set_req(3, 4'hF, 4'h1);
    #1;
    n_tests++;
    if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL rst_grant3: got %b expected 1000", req_ready); end
    tick;
    req_valid = '0;
    RESET = 1'b1;
    #1;
    n_tests++;
    if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_ready_low: got %b expected 0000", req_ready); end
    tick;
    n_tests++;
    if (resp_valid !== 1'b0 || resp_id !== 2'd0 || resp_gt !== 1'b0) begin
      n_fail++; $display("FAIL rst_outputs: got v=%b id=%0d gt=%b expected 0/0/0", resp_valid, resp_id, resp_gt);
    end
    RESET = 1'b0;
    tick;
    n_tests++;
    if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_no_resp: got %b expected 0", resp_valid); end
    for (int k = 0; k < N; k++) set_req(k, 4'h8, 4'h4);
    #1;
    n_tests++;
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rst_next_grant: got %b expected 0001", req_ready); end
    tick;
    req_valid = '0;
    tick;
    n_tests++;
    if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_gt !== 1'b1) begin
      n_fail++; $display("FAIL rst_resp0: got v=%b id=%0d gt=%b expected v=1 id=0 gt=1", resp_valid, resp_id, resp_gt);
    end
    $display("[TB] post-reset txn id=%0d gt=%b", resp_id, resp_gt);
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
  endtask

`ifdef UGT_SHARE_ARBITER_STATS_EN
  task automatic run_txn(input int k, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    set_req(k, a, b);
    tick;
    req_valid = '0;
    tick;
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    $display("[TB] stats txn req=%0d", k);
  endtask

  task automatic test_stats;
    RESET = 1'b1;
    tick;
    RESET = 1'b0;
    n_tests++;
    if (txn_count !== 16'd0 || last_grant_onehot !== 4'b0000) begin
      n_fail++; $display("FAIL stats_reset: got cnt=%0d oh=%b expected 0/0000", txn_count, last_grant_onehot);
    end
    run_txn(2, 4'h1, 4'h2);
    run_txn(0, 4'h5, 4'h2);
    run_txn(1, 4'h6, 4'h6);
    n_tests++;
    if (txn_count !== 16'd3) begin n_fail++; $display("FAIL stats_count3: got %0d expected 3", txn_count); end
    n_tests++;
    if (last_grant_onehot !== 4'b0010) begin n_fail++; $display("FAIL stats_onehot: got %b expected 0010", last_grant_onehot); end
    force dut.r_txn_count = 16'hFFFE;
    tick;
    release dut.r_txn_count;
    run_txn(3, 4'h4, 4'h1);
    n_tests++;
    if (txn_count !== 16'hFFFF) begin n_fail++; $display("FAIL stats_reach_max: got %h expected ffff", txn_count); end
    run_txn(0, 4'h4, 4'h1);
    n_tests++;
    if (txn_count !== 16'hFFFF) begin n_fail++; $display("FAIL stats_saturate: got %h expected ffff", txn_count); end
  endtask
`endif

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    RESET      = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    test_reset;
    test_single;
    test_round_robin;
    test_backpressure;
    test_reset_mid;
`ifdef UGT_SHARE_ARBITER_STATS_EN
    test_stats;
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
